sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter PORTS, default 3, number of requester ports (legal 2..4).
REQ-002 SHALL have parameter AW, default 24, address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port ready, input, 1, SDRAM controller initialised; no grant while low.
REQ-007 SHALL have port rfsh, input, 1, refresh request pulse.
REQ-008 SHALL have port req, input, PORTS, per-port access request, level.
REQ-009 SHALL have port we, input, PORTS, per-port write (1) / read (0), qualified by req.
REQ-010 SHALL have port a, input, PORTS*AW, packed addresses, port n at [n*AW +: AW].
REQ-011 SHALL have port d, input, PORTS*DW, packed write data, port n at [n*DW +: DW].
REQ-012 SHALL have port q, output, DW, read data, shared by all ports.
REQ-013 SHALL have port ack, output, PORTS, one-hot completion pulse.
REQ-014 SHALL have ports memRd, memWr, memRf, output, 1 each, one-cycle command strobes to the controller.
REQ-015 SHALL have ports memA (output, AW), memD (output, DW), memQ (input, DW), memBusy (input, 1, controller executing).

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if ready=1 and refresh pending -> ISSUE with memRf; else if ready=1 and any req -> ISSUE for the selected port; else stay.
REQ-018 Refresh SHALL always win over port requests in the same IDLE cycle.
REQ-019 rfsh pulses SHALL set a pending flag; the flag SHALL clear on the ISSUE cycle that asserts memRf; multiple pulses while pending SHALL coalesce into one.
REQ-020 rfsh arriving during ISSUE/WAIT/DONE SHALL remain pending and be served at the next IDLE.
REQ-021 On entering ISSUE, a, d and we of the granted port SHALL be latched into memA, memD and an internal write flag; memA/memD SHALL hold until DONE.
REQ-022 ISSUE SHALL last exactly one cycle, asserting exactly one of memRd/memWr/memRf, then go to WAIT.
REQ-023 WAIT SHALL exit to DONE on the first cycle memBusy=0, sampling memBusy no earlier than the cycle after ISSUE.
REQ-024 DONE SHALL last one cycle: for a read, q<=memQ; ack bit of the granted port =1 (no ack for refresh); then IDLE.
REQ-025 q SHALL hold its value until the next completed read.
REQ-026 Minimum latency SHALL be 3 cycles from the IDLE grant cycle to the ack cycle (memBusy already low).
REQ-027 A port SHALL drop req in the cycle ack is high; req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-028 req deasserted before ack SHALL NOT abort an issued access; ack SHALL still pulse.
REQ-029 ready falling outside IDLE SHALL NOT abort the current access.
REQ-030 Ports with index >= PORTS SHALL not exist; the arbiter SHALL never grant an out-of-range index.

Reset
REQ-031 reset=1 at any clock edge SHALL force IDLE, clear refresh pending, and set memRd=memWr=memRf=0, ack=0, q=0, memA=0, memD=0, priority pointer=0.
REQ-032 Reset mid-access SHALL abandon it without ack; the downstream controller is not reset by this block.

Configuration
REQ-033 With SDRAM_ARB_RR_EN defined, selection SHALL be round-robin: search starts at port (last granted+1) mod PORTS; pointer updates only on port grants, not refresh.
REQ-034 Without SDRAM_ARB_RR_EN, selection SHALL be fixed priority, lowest index highest.

Verification
REQ-035 Single read: PORTS=3, req[1]=1, we=0, a1=24'h012345, memBusy low 2 cycles after ISSUE, memQ=16'hA55A -> memRd 1 cycle, memA=24'h012345, ack=3'b010, q=16'hA55A.
REQ-036 Refresh collision: rfsh pulse and req[0] in the same IDLE cycle -> memRf issued first, then memWr/memRd for port 0; two rfsh pulses during WAIT -> exactly one memRf afterwards.
REQ-037 Round-robin (macro defined): req=3'b111 held continuously, re-raised after each ack -> ack order 001,010,100,001; without macro -> 001 on every grant.
REQ-038 Ready gating: ready=0 with req[2]=1 for 10 cycles -> no strobes; ready=1 -> memRd/memWr within 1 cycle.
REQ-039 Reset mid-WAIT: reset=1 for one cycle during WAIT -> next cycle IDLE, ack=0, q=0, memA=0, no ack ever issued for that access.
REQ-040 Write: req[0]=1, we[0]=1, d0=16'h00C3 -> memWr 1 cycle, memD=16'h00C3, ack=3'b001, q unchanged.

Source files
------------

// File: rtl/sdram_arb.sv
// ---------------------------------------------------------------------------
// sdram_arb
//
// Multi-port arbiter in front of a single-command SDRAM controller. Each
// requester raises req (level) together with we/a/d. The arbiter picks one
// port, or a pending refresh, and issues a single one-cycle command strobe.
// It waits for the controller to finish and then pulses a one-hot ack back
// to the granted port. Refresh always beats port traffic.
//
// Configuration macro:
//   SDRAM_ARB_RR_EN  defined   -> round-robin selection starting after the
//                                 last granted port
//                    undefined -> fixed priority, lowest port index wins
//
// Parameters:
//   PORTS  number of requester ports (2..4)
//   AW     address width
//   DW     data width
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   ready            controller initialised; nothing is granted while low
//   rfsh             refresh request pulse (coalesced while pending)
//   req, we          per-port request level and write(1)/read(0) select
//   a, d             packed per-port address / write data (port n at n*W)
//   q                shared read data, held until the next completed read
//   ack              one-hot completion pulse to the granted port
//   memRd/Wr/Rf      one-cycle command strobes to the controller
//   memA, memD       latched address / write data for the current command
//   memQ             controller read data
//   memBusy          controller still executing the current command
// ---------------------------------------------------------------------------
module sdram_arb #(
    parameter int PORTS = 3,
    parameter int AW    = 24,
    parameter int DW    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ready,
    input  logic                rfsh,
    input  logic [PORTS-1:0]    req,
    input  logic [PORTS-1:0]    we,
    input  logic [PORTS*AW-1:0] a,
    input  logic [PORTS*DW-1:0] d,
    output logic [DW-1:0]       q,
    output logic [PORTS-1:0]    ack,
    output logic                memRd,
    output logic                memWr,
    output logic                memRf,
    output logic [AW-1:0]       memA,
    output logic [DW-1:0]       memD,
    input  logic [DW-1:0]       memQ,
    input  logic                memBusy
);

    localparam int IW = (PORTS > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbStateT;

    arbStateT        state;
    arbStateT        nextState;

    logic            rfPending;
    logic            refreshWanted;
    logic            grantRf;
    logic            grantPort;
    logic            isRefresh;
    logic            isWrite;
    logic [IW-1:0]   grantIdx;
    logic [IW-1:0]   searchStart;

    logic            found;
    int              scanIdx;
    logic [IW-1:0]   selIdx;
    logic [AW-1:0]   selA;
    logic [DW-1:0]   selD;
    logic            selWe;

    // A refresh pulse arriving in the very IDLE cycle that grants still counts,
    // so it must beat a simultaneous port request instead of waiting a cycle.
    assign refreshWanted = rfPending | rfsh;
    assign grantRf       = (state == IDLE) && ready && refreshWanted;
    assign grantPort     = (state == IDLE) && ready && !refreshWanted && (|req);

`ifdef SDRAM_ARB_RR_EN
    logic [IW-1:0] rrPtr;

    // Round-robin pointer: next search begins just after the last granted
    // port. Refresh grants leave it untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (grantPort) begin
            rrPtr <= (selIdx == IW'(PORTS - 1)) ? '0 : selIdx + IW'(1);
        end
    end

    assign searchStart = rrPtr;
`else
    assign searchStart = '0;
`endif

    // Scan every port once, starting at searchStart and wrapping modulo PORTS.
    // The first requesting port found wins; indices >= PORTS never appear.
    always_comb begin
        found   = 1'b0;
        scanIdx = 0;
        selIdx  = '0;
        selA    = '0;
        selD    = '0;
        selWe   = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            scanIdx = int'(searchStart) + k;
            if (scanIdx >= PORTS) begin
                scanIdx = scanIdx - PORTS;
            end
            if (!found && req[scanIdx]) begin
                found  = 1'b1;
                selIdx = IW'(scanIdx);
                selA   = a[scanIdx*AW +: AW];
                selD   = d[scanIdx*DW +: DW];
                selWe  = we[scanIdx];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. ISSUE and DONE are single cycles; WAIT only looks at
    // memBusy from the cycle after the strobe, so the controller has had one
    // edge to raise it. ready only gates new grants, never a running access.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grantRf || grantPort) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT:    if (!memBusy) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Command latch, refresh bookkeeping and read-data capture. Read data is
    // captured on the WAIT->DONE edge so q is already valid while ack pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rfPending <= 1'b0;
            isRefresh <= 1'b0;
            isWrite   <= 1'b0;
            grantIdx  <= '0;
            memA      <= '0;
            memD      <= '0;
            q         <= '0;
        end else begin
            if (grantRf) begin
                rfPending <= 1'b0;
            end else if (rfsh) begin
                rfPending <= 1'b1;
            end

            if (grantRf) begin
                isRefresh <= 1'b1;
                isWrite   <= 1'b0;
            end else if (grantPort) begin
                isRefresh <= 1'b0;
                isWrite   <= selWe;
                grantIdx  <= selIdx;
                memA      <= selA;
                memD      <= selD;
            end

            if ((state == WAIT) && !memBusy && !isRefresh && !isWrite) begin
                q <= memQ;
            end
        end
    end

    // Strobes are decoded from the registered state so each lasts exactly the
    // one ISSUE cycle, and exactly one of them is ever high.
    assign memRd = (state == ISSUE) && !isRefresh && !isWrite;
    assign memWr = (state == ISSUE) && !isRefresh &&  isWrite;
    assign memRf = (state == ISSUE) &&  isRefresh;

    // One-hot completion pulse for port accesses only.
    always_comb begin
        ack = '0;
        for (int p = 0; p < PORTS; p++) begin
            ack[p] = (state == DONE) && !isRefresh && (grantIdx == IW'(p));
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// ---------------------------------------------------------------------------
// tb_sdram_arb
//
// Directed bench for sdram_arb with PORTS=3, AW=24, DW=16. Inputs are driven
// and outputs sampled on the falling clock edge; every DUT output is a
// function of registered state, so falling-edge samples are stable.
// Expected round-robin order follows SDRAM_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_sdram_arb;

    localparam int PORTS = 3;
    localparam int AW    = 24;
    localparam int DW    = 16;

    logic                clock;
    logic                reset;
    logic                ready;
    logic                rfsh;
    logic [PORTS-1:0]    req;
    logic [PORTS-1:0]    we;
    logic [PORTS*AW-1:0] a;
    logic [PORTS*DW-1:0] d;
    logic [DW-1:0]       q;
    logic [PORTS-1:0]    ack;
    logic                memRd;
    logic                memWr;
    logic                memRf;
    logic [AW-1:0]       memA;
    logic [DW-1:0]       memD;
    logic [DW-1:0]       memQ;
    logic                memBusy;

    int compared;
    int mismatched;

    sdram_arb #(.PORTS(PORTS), .AW(AW), .DW(DW)) dut (
        .clock   (clock),
        .reset   (reset),
        .ready   (ready),
        .rfsh    (rfsh),
        .req     (req),
        .we      (we),
        .a       (a),
        .d       (d),
        .q       (q),
        .ack     (ack),
        .memRd   (memRd),
        .memWr   (memWr),
        .memRf   (memRf),
        .memA    (memA),
        .memD    (memD),
        .memQ    (memQ),
        .memBusy (memBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++;
        if ({memRd, memWr, memRf} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_strobes: got %b expected 000", {memRd, memWr, memRf});
        end
        compared++;
        if (ack !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_ack: got %b expected 000", ack);
        end
        compared++;
        if (q !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_q: got %h expected 0000", q);
        end
        compared++;
        if (memA !== 24'h000000 || memD !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_memAD: got %h/%h expected 000000/0000", memA, memD);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        a[0*AW +: AW] = 24'h111111;
        a[1*AW +: AW] = 24'h012345;
        a[2*AW +: AW] = 24'h222222;
        we      = 3'b000;
        memQ    = 16'hA55A;
        memBusy = 1'b0;
        req     = 3'b010;
        tick();
        compared++;
        if ({memRd, memWr, memRf} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL read_strobe: got %b expected 100", {memRd, memWr, memRf});
        end
        compared++;
        if (memA !== 24'h012345) begin
            mismatched++;
            $display("[TB] FAIL read_memA: got %h expected 012345", memA);
        end
        memBusy = 1'b1;
        tick();
        compared++;
        if (memRd !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_strobe_len: got %b expected 0", memRd);
        end
        tick();
        memBusy = 1'b0;
        compared++;
        if (ack !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL read_early_ack: got %b expected 000", ack);
        end
        tick();
        compared++;
        if (ack !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL read_ack: got %b expected 010", ack);
        end
        req = 3'b000;
        tick();
        compared++;
        if (ack !== 3'b000 || q !== 16'hA55A) begin
            mismatched++;
            $display("[TB] FAIL read_q: got ack=%b q=%h expected ack=000 q=a55a", ack, q);
        end
    endtask

    task automatic test_write();
        a[0*AW +: AW] = 24'h000777;
        d[0*DW +: DW] = 16'h00C3;
        d[1*DW +: DW] = 16'h1111;
        d[2*DW +: DW] = 16'h2222;
        we  = 3'b001;
        req = 3'b001;
        tick();
        compared++;
        if ({memRd, memWr, memRf} !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL write_strobe: got %b expected 010", {memRd, memWr, memRf});
        end
        compared++;
        if (memD !== 16'h00C3 || memA !== 24'h000777) begin
            mismatched++;
            $display("[TB] FAIL write_memAD: got %h/%h expected 000777/00c3", memA, memD);
        end
        tick();
        compared++;
        if (memWr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_strobe_len: got %b expected 0", memWr);
        end
        tick();
        compared++;
        if (ack !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL write_ack_latency3: got %b expected 001", ack);
        end
        req = 3'b000;
        we  = 3'b000;
        tick();
        compared++;
        if (q !== 16'hA55A) begin
            mismatched++;
            $display("[TB] FAIL write_q_hold: got %h expected a55a", q);
        end
    endtask

    task automatic test_refresh_collision();
        int rfCount;
        int rdCount;
        int ackCount;
        int rfCycle;
        int rdCycle;
        logic [PORTS-1:0] ackSeen;
        rfCount  = 0;
        rdCount  = 0;
        ackCount = 0;
        rfCycle  = -1;
        rdCycle  = -1;
        ackSeen  = '0;
        a[0*AW +: AW] = 24'h000100;
        memQ = 16'h1234;
        we   = 3'b000;
        rfsh = 1'b1;
        req  = 3'b001;
        tick();
        rfsh = 1'b0;
        compared++;
        if ({memRd, memWr, memRf} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL collision_rf_first: got %b expected 001", {memRd, memWr, memRf});
        end
        tick();
        memBusy = 1'b1;
        rfsh    = 1'b1;
        tick();
        rfsh = 1'b0;
        tick();
        rfsh = 1'b1;
        tick();
        rfsh    = 1'b0;
        memBusy = 1'b0;
        tick();
        compared++;
        if (ack !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL collision_rf_noack: got %b expected 000", ack);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (memRf) begin
                rfCount++;
                rfCycle = i;
            end
            if (memRd) begin
                rdCount++;
                rdCycle = i;
            end
            if (ack != 3'b000) begin
                ackCount++;
                ackSeen = ack;
                req = 3'b000;
            end
        end
        compared++;
        if (rfCount != 1 || rfCycle != 1) begin
            mismatched++;
            $display("[TB] FAIL collision_one_rf: got count=%0d at=%0d expected count=1 at=1", rfCount, rfCycle);
        end
        compared++;
        if (rdCount != 1 || rdCycle != 5) begin
            mismatched++;
            $display("[TB] FAIL collision_rd_after: got count=%0d at=%0d expected count=1 at=5", rdCount, rdCycle);
        end
        compared++;
        if (ackCount != 1 || ackSeen !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL collision_ack: got count=%0d ack=%b expected count=1 ack=001", ackCount, ackSeen);
        end
        compared++;
        if (q !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL collision_q: got %h expected 1234", q);
        end
    endtask

    task automatic test_ready_gating();
        int strobes;
        strobes = 0;
        ready = 1'b0;
        req   = 3'b100;
        we    = 3'b000;
        a[2*AW +: AW] = 24'h0ABCDE;
        memQ = 16'h0F0F;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (memRd || memWr || memRf) strobes++;
        end
        compared++;
        if (strobes != 0) begin
            mismatched++;
            $display("[TB] FAIL gating_no_strobe: got %0d expected 0", strobes);
        end
        ready = 1'b1;
        tick();
        compared++;
        if (memRd !== 1'b1 || memA !== 24'h0ABCDE) begin
            mismatched++;
            $display("[TB] FAIL gating_release: got rd=%b a=%h expected rd=1 a=0abcde", memRd, memA);
        end
        ready = 1'b0;
        tick();
        tick();
        compared++;
        if (ack !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL gating_ready_drop_ack: got %b expected 100", ack);
        end
        req   = 3'b000;
        ready = 1'b1;
        tick();
        compared++;
        if (q !== 16'h0F0F) begin
            mismatched++;
            $display("[TB] FAIL gating_q: got %h expected 0f0f", q);
        end
    endtask

    task automatic test_round_robin();
        int expIdx [4];
        logic [PORTS-1:0] expAck;
        logic [AW-1:0]    expA;
`ifdef SDRAM_ARB_RR_EN
        expIdx = '{0, 1, 2, 0};
`else
        expIdx = '{0, 0, 0, 0};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a[0*AW +: AW] = 24'h100000;
        a[1*AW +: AW] = 24'h200000;
        a[2*AW +: AW] = 24'h300000;
        we   = 3'b000;
        memQ = 16'h5151;
        for (int i = 0; i < 4; i++) begin
            expAck = 3'b001 << expIdx[i];
            expA   = 24'h100000 * (expIdx[i] + 1);
            req    = 3'b111;
            tick();
            compared++;
            if (memRd !== 1'b1 || memA !== expA) begin
                mismatched++;
                $display("[TB] FAIL rr_issue_%0d: got rd=%b a=%h expected rd=1 a=%h", i, memRd, memA, expA);
            end
            tick();
            tick();
            compared++;
            if (ack !== expAck) begin
                mismatched++;
                $display("[TB] FAIL rr_ack_%0d: got %b expected %b", i, ack, expAck);
            end
            req = 3'b111 & ~expAck;
            tick();
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int ackCount;
        int strobes;
        ackCount = 0;
        strobes  = 0;
        a[1*AW +: AW] = 24'h00FFFF;
        d[1*DW +: DW] = 16'h7777;
        we   = 3'b000;
        memQ = 16'hBEEF;
        req  = 3'b010;
        tick();
        memBusy = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if (ack !== 3'b000 || q !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_ack_q: got ack=%b q=%h expected ack=000 q=0000", ack, q);
        end
        compared++;
        if (memA !== 24'h000000 || memD !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_memAD: got %h/%h expected 000000/0000", memA, memD);
        end
        req     = 3'b000;
        memBusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack != 3'b000) ackCount++;
            if (memRd || memWr || memRf) strobes++;
        end
        compared++;
        if (ackCount != 0 || strobes != 0) begin
            mismatched++;
            $display("[TB] FAIL midreset_no_ack: got acks=%0d strobes=%0d expected 0/0", ackCount, strobes);
        end
        compared++;
        if (q !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_q_hold: got %h expected 0000", q);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset   = 1'b1;
        ready   = 1'b1;
        rfsh    = 1'b0;
        req     = '0;
        we      = '0;
        a       = '0;
        d       = '0;
        memQ    = '0;
        memBusy = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_write();
        test_refresh_collision();
        test_ready_gating();
        test_round_robin();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
